// File: rtl/tl_scratch_responder_pkg.sv
// Shared TileLink-UL types for the scratchpad responder.
// Opcodes, D-channel bundle, FSM states and the byte-mask helper.
package tl_pkg;

   localparam logic [2:0] A_PUT_FULL = 3'd0;
   localparam logic [2:0] A_PUT_PART = 3'd1;
   localparam logic [2:0] A_ARITH    = 3'd2;
   localparam logic [2:0] A_LOGIC    = 3'd3;
   localparam logic [2:0] A_GET      = 3'd4;
   localparam logic [2:0] A_INTENT   = 3'd5;

   localparam logic [2:0] D_ACK      = 3'd0;
   localparam logic [2:0] D_ACK_DATA = 3'd1;
   localparam logic [2:0] D_HINT_ACK = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_RESP
   } state_e;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  param;
      logic [3:0]  size;
      logic [2:0]  source;
      logic        sink;
      logic        denied;
      logic        corrupt;
      logic [63:0] data;
   } d_bundle_t;

   function automatic logic [7:0] byte_mask(
      input logic [3:0] size,
      input logic [2:0] lane
   );
      logic [7:0] m;
      case (size)
         4'd0:    m = 8'h01;
         4'd1:    m = 8'h03;
         4'd2:    m = 8'h0F;
         4'd3:    m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m << lane;
   endfunction

endpackage

// File: rtl/tl_scratch_responder_if.sv
// TileLink-UL A/D channel bundle between a requester and the responder.
// The master drives A and d_ready; the slave drives D and a_ready.
interface tl_scratch_responder_if;

   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_bits_opcode;
   logic [2:0]  a_bits_param;
   logic [3:0]  a_bits_size;
   logic [2:0]  a_bits_source;
   logic [31:0] a_bits_address;
   logic [63:0] a_bits_data;
   logic        a_bits_corrupt;

   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_bits_opcode;
   logic [1:0]  d_bits_param;
   logic [3:0]  d_bits_size;
   logic [2:0]  d_bits_source;
   logic        d_bits_sink;
   logic        d_bits_denied;
   logic        d_bits_corrupt;
   logic [63:0] d_bits_data;

   modport master (
      output a_valid, a_bits_opcode, a_bits_param, a_bits_size,
      output a_bits_source, a_bits_address, a_bits_data, a_bits_corrupt,
      output d_ready,
      input  a_ready,
      input  d_valid, d_bits_opcode, d_bits_param, d_bits_size,
      input  d_bits_source, d_bits_sink, d_bits_denied, d_bits_corrupt,
      input  d_bits_data
   );

   modport slave (
      input  a_valid, a_bits_opcode, a_bits_param, a_bits_size,
      input  a_bits_source, a_bits_address, a_bits_data, a_bits_corrupt,
      input  d_ready,
      output a_ready,
      output d_valid, d_bits_opcode, d_bits_param, d_bits_size,
      output d_bits_source, d_bits_sink, d_bits_denied, d_bits_corrupt,
      output d_bits_data
   );

endinterface

// File: rtl/tl_scratch_responder_ram.sv
// Single-port synchronous scratch RAM, 64-bit words, byte write enables.
// Read data appears one cycle after an enabled access.
module scratch_ram_sp #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [7:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [63:0]   wdata_i,
   output logic [63:0]   rdata_o
);

   logic [63:0] mem_q [DEPTH];
   logic [63:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < 8; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_scratch_responder.sv
// TileLink-UL manager terminating a bus slot with a single-beat scratchpad.
// One request in flight; the D response is held until d_ready.
module tl_scratch_responder
   import tl_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          DEPTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   tl_scratch_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   state_e        state_q, state_d;
   d_bundle_t     d_q, d_d;
   logic          accept;
   logic          aligned;
   logic          in_rng;
   logic          legal;
   logic          ram_en;
   logic [7:0]    ram_we;
   logic [63:0]   ram_rdata;
   logic [AW-1:0] ram_addr;
   logic          unused_param;

   assign unused_param = ^bus.a_bits_param;

   assign bus.a_ready = (state_q == S_IDLE) & ~reset;
   assign accept      = bus.a_valid & bus.a_ready;

   always_comb begin
      aligned = 1'b0;
      case (bus.a_bits_size)
         4'd0:    aligned = 1'b1;
         4'd1:    aligned = ~bus.a_bits_address[0];
         4'd2:    aligned = bus.a_bits_address[1:0] == 2'b0;
         4'd3:    aligned = bus.a_bits_address[2:0] == 3'b0;
         default: aligned = 1'b0;
      endcase
   end

   // BASE is window-aligned, so the upper bits alone decide membership
   assign in_rng   = bus.a_bits_address[31:AW+3] == BASE[31:AW+3];
   assign legal    = aligned & in_rng;
   assign ram_addr = bus.a_bits_address[AW+2:3];

   scratch_ram_sp #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (clock),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (bus.a_bits_data),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      ram_en  = 1'b0;
      ram_we  = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               d_d        = '0;
               d_d.size   = bus.a_bits_size;
               d_d.source = bus.a_bits_source;
               state_d    = S_RESP;
               case (bus.a_bits_opcode)
                  A_GET: begin
                     d_d.opcode = D_ACK_DATA;
                     if (legal) begin
                        ram_en  = 1'b1;
                        state_d = S_READ;
                     end else begin
                        d_d.denied  = 1'b1;
                        d_d.corrupt = 1'b1;
                     end
                  end
                  A_PUT_FULL, A_PUT_PART: begin
                     d_d.opcode = D_ACK;
                     if (legal & ~bus.a_bits_corrupt) begin
                        ram_en = 1'b1;
                        ram_we = byte_mask(bus.a_bits_size,
                                           bus.a_bits_address[2:0]);
                     end else begin
                        d_d.denied = 1'b1;
                     end
                  end
                  A_ARITH, A_LOGIC: begin
                     d_d.opcode  = D_ACK_DATA;
                     d_d.denied  = 1'b1;
                     d_d.corrupt = 1'b1;
                  end
                  A_INTENT: d_d.opcode = D_HINT_ACK;
                  default: begin
                     d_d.opcode = D_ACK;
                     d_d.denied = 1'b1;
                  end
               endcase
            end
         end
         S_READ: begin
            d_d.data = ram_rdata;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (bus.d_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
      end
   end

   assign bus.d_valid        = state_q == S_RESP;
   assign bus.d_bits_opcode  = d_q.opcode;
   assign bus.d_bits_param   = d_q.param;
   assign bus.d_bits_size    = d_q.size;
   assign bus.d_bits_source  = d_q.source;
   assign bus.d_bits_sink    = d_q.sink;
   assign bus.d_bits_denied  = d_q.denied;
   assign bus.d_bits_corrupt = d_q.corrupt;
   assign bus.d_bits_data    = d_q.data;

endmodule

// File: tb/tb_tl_scratch_responder.sv
// Directed self-checking bench for tl_scratch_responder.
// Each task drives one scenario and checks its responses inline.
module tb_tl_scratch_responder;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   tl_scratch_responder_if bus ();

   tl_scratch_responder #(.BASE(BASE), .DEPTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [78:0] dsnap;
   assign dsnap = {bus.d_bits_opcode, bus.d_bits_param, bus.d_bits_size,
                   bus.d_bits_source, bus.d_bits_sink, bus.d_bits_denied,
                   bus.d_bits_corrupt, bus.d_bits_data};

   int          r_lat;
   logic [2:0]  r_op;
   logic [2:0]  r_pz;
   logic [3:0]  r_size;
   logic [2:0]  r_src;
   logic        r_den;
   logic        r_cor;
   logic [63:0] r_data;

   task automatic send(input logic [2:0] op, input logic [3:0] sz,
                       input logic [2:0] src, input logic [31:0] off,
                       input logic [63:0] data, input logic cor);
      int n;
      n = 0;
      bus.a_bits_opcode  = op;
      bus.a_bits_param   = 3'd0;
      bus.a_bits_size    = sz;
      bus.a_bits_source  = src;
      bus.a_bits_address = BASE + off;
      bus.a_bits_data    = data;
      bus.a_bits_corrupt = cor;
      bus.a_valid        = 1'b1;
      while (bus.a_ready !== 1'b1 && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
      bus.a_valid = 1'b0;
   endtask

   task automatic wait_dv();
      r_lat = 0;
      while (bus.d_valid !== 1'b1 && r_lat < 20) begin
         @(posedge clock); #1;
         r_lat++;
      end
      if (bus.d_valid !== 1'b1) r_lat = 99;
      r_op   = bus.d_bits_opcode;
      r_pz   = {bus.d_bits_param, bus.d_bits_sink};
      r_size = bus.d_bits_size;
      r_src  = bus.d_bits_source;
      r_den  = bus.d_bits_denied;
      r_cor  = bus.d_bits_corrupt;
      r_data = bus.d_bits_data;
   endtask

   task automatic recv();
      wait_dv();
      if (r_lat != 99) begin
         bus.d_ready = 1'b1;
         @(posedge clock); #1;
         bus.d_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({bus.a_ready, bus.d_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_hs: got %b want 00", {bus.a_ready, bus.d_valid});
      end
      n_cmp++;
      if (dsnap !== 79'd0) begin
         n_fail++;
         $display("FAIL reset_dbits: got %h want 0", dsnap);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.a_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: a_ready got %b want 1", bus.a_ready);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_put_get();
      send(3'd0, 4'd3, 3'd1, 32'h8, 64'h1122334455667788, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor, r_size, r_src, r_pz} !==
          {3'd0, 1'b0, 1'b0, 4'd3, 3'd1, 3'd0}) begin
         n_fail++;
         $display("FAIL put_ack: got op=%0d den=%b cor=%b sz=%0d src=%0d pz=%0d want 0/0/0/3/1/0",
                  r_op, r_den, r_cor, r_size, r_src, r_pz);
      end
      n_cmp++;
      if (r_lat !== 0 || r_data !== 64'd0) begin
         n_fail++;
         $display("FAIL put_lat: got lat=%0d data=%h want 0/0", r_lat, r_data);
      end
      send(3'd4, 4'd3, 3'd2, 32'h8, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor, r_src} !== {3'd1, 1'b0, 1'b0, 3'd2}) begin
         n_fail++;
         $display("FAIL get_ack: got op=%0d den=%b cor=%b src=%0d want 1/0/0/2",
                  r_op, r_den, r_cor, r_src);
      end
      n_cmp++;
      if (r_lat !== 1) begin
         n_fail++;
         $display("FAIL get_lat: got %0d want 1", r_lat);
      end
      n_cmp++;
      if (r_data !== 64'h1122334455667788) begin
         n_fail++;
         $display("FAIL get_data: got %h want 1122334455667788", r_data);
      end
   endtask

   task automatic test_byte_write();
      send(3'd0, 4'd3, 3'd0, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      recv();
      send(3'd0, 4'd0, 3'd2, 32'hB, 64'h0000_0000_AB00_0000, 1'b0);
      recv();
      n_cmp++;
      if ({r_lat[3:0], r_op, r_den, r_size, r_src} !==
          {4'd0, 3'd0, 1'b0, 4'd0, 3'd2}) begin
         n_fail++;
         $display("FAIL byte_ack: got lat=%0d op=%0d den=%b sz=%0d src=%0d",
                  r_lat, r_op, r_den, r_size, r_src);
      end
      send(3'd4, 4'd3, 3'd0, 32'h8, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hFFFF_FFFF_ABFF_FFFF) begin
         n_fail++;
         $display("FAIL byte_data: got %h want ffffffffabffffff", r_data);
      end
      send(3'd1, 4'd1, 3'd3, 32'hC, 64'h0000_1234_0000_0000, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL partial_ack: got op=%0d den=%b want 0/0", r_op, r_den);
      end
      send(3'd4, 4'd3, 3'd0, 32'h8, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hFFFF_1234_ABFF_FFFF) begin
         n_fail++;
         $display("FAIL partial_data: got %h want ffff1234abffffff", r_data);
      end
   endtask

   task automatic test_illegal();
      send(3'd0, 4'd3, 3'd0, 32'h0, 64'hCAFE_BABE_DEAD_BEEF, 1'b0);
      recv();
      send(3'd4, 4'd3, 3'd0, 32'h80, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_lat[3:0], r_op, r_den, r_cor, r_data} !==
          {4'd0, 3'd1, 1'b1, 1'b1, 64'd0}) begin
         n_fail++;
         $display("FAIL get_oor: got lat=%0d op=%0d den=%b cor=%b data=%h",
                  r_lat, r_op, r_den, r_cor, r_data);
      end
      send(3'd4, 4'd2, 3'd0, 32'h2, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor, r_data} !== {3'd1, 1'b1, 1'b1, 64'd0}) begin
         n_fail++;
         $display("FAIL get_misalign: got op=%0d den=%b cor=%b data=%h",
                  r_op, r_den, r_cor, r_data);
      end
      send(3'd4, 4'd3, 3'd0, 32'hFFFF_FFF8, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor} !== {3'd1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL get_below: got op=%0d den=%b cor=%b", r_op, r_den, r_cor);
      end
      send(3'd4, 4'd4, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor} !== {3'd1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL get_size4: got op=%0d den=%b cor=%b", r_op, r_den, r_cor);
      end
      send(3'd0, 4'd3, 3'd0, 32'h80, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_lat[3:0], r_op, r_den} !== {4'd0, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL put_oor: got lat=%0d op=%0d den=%b", r_lat, r_op, r_den);
      end
      send(3'd0, 4'd3, 3'd0, 32'h9, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den} !== {3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL put_misalign: got op=%0d den=%b", r_op, r_den);
      end
      send(3'd4, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hCAFE_BABE_DEAD_BEEF) begin
         n_fail++;
         $display("FAIL illegal_w0: got %h want cafebabedeadbeef", r_data);
      end
      send(3'd4, 4'd3, 3'd0, 32'h8, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hFFFF_1234_ABFF_FFFF) begin
         n_fail++;
         $display("FAIL illegal_w1: got %h want ffff1234abffffff", r_data);
      end
   endtask

   task automatic test_corrupt();
      send(3'd0, 4'd3, 3'd4, 32'h0, 64'd0, 1'b1);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor, r_src} !== {3'd0, 1'b1, 1'b0, 3'd4}) begin
         n_fail++;
         $display("FAIL corrupt_ack: got op=%0d den=%b cor=%b src=%0d",
                  r_op, r_den, r_cor, r_src);
      end
      send(3'd4, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hCAFE_BABE_DEAD_BEEF) begin
         n_fail++;
         $display("FAIL corrupt_keep: got %h want cafebabedeadbeef", r_data);
      end
   endtask

   task automatic test_unsupported();
      send(3'd2, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_lat[3:0], r_op, r_den, r_cor, r_data} !==
          {4'd0, 3'd1, 1'b1, 1'b1, 64'd0}) begin
         n_fail++;
         $display("FAIL arith: got lat=%0d op=%0d den=%b cor=%b data=%h",
                  r_lat, r_op, r_den, r_cor, r_data);
      end
      send(3'd3, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor} !== {3'd1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL logical: got op=%0d den=%b cor=%b", r_op, r_den, r_cor);
      end
      send(3'd6, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_op, r_den, r_cor} !== {3'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL op6: got op=%0d den=%b cor=%b", r_op, r_den, r_cor);
      end
      send(3'd4, 4'd3, 3'd0, 32'h0, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'hCAFE_BABE_DEAD_BEEF) begin
         n_fail++;
         $display("FAIL unsup_keep: got %h want cafebabedeadbeef", r_data);
      end
   endtask

   task automatic test_stall();
      logic [78:0] snap;
      send(3'd4, 4'd3, 3'd5, 32'h8, 64'd0, 1'b0);
      wait_dv();
      snap = dsnap;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         n_cmp++;
         if ({bus.d_valid, bus.a_ready, dsnap} !== {1'b1, 1'b0, snap}) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d dv=%b ar=%b bits=%h want 1/0/%h",
                     i, bus.d_valid, bus.a_ready, dsnap, snap);
         end
      end
      n_cmp++;
      if ({r_size, r_src, r_op, r_data} !==
          {4'd3, 3'd5, 3'd1, 64'hFFFF_1234_ABFF_FFFF}) begin
         n_fail++;
         $display("FAIL stall_echo: got sz=%0d src=%0d op=%0d data=%h",
                  r_size, r_src, r_op, r_data);
      end
      bus.d_ready = 1'b1;
      @(posedge clock); #1;
      bus.d_ready = 1'b0;
      n_cmp++;
      if ({bus.d_valid, bus.a_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_release: got dv=%b ar=%b want 0/1",
                  bus.d_valid, bus.a_ready);
      end
   endtask

   task automatic test_reset_mid();
      send(3'd4, 4'd3, 3'd1, 32'h8, 64'd0, 1'b0);
      wait_dv();
      reset = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if ({bus.d_valid, bus.a_ready, bus.d_bits_data} !== {1'b0, 1'b0, 64'd0}) begin
         n_fail++;
         $display("FAIL rstmid_drop: got dv=%b ar=%b data=%h want 0/0/0",
                  bus.d_valid, bus.a_ready, bus.d_bits_data);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.a_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready: got %b want 1", bus.a_ready);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_intent();
      send(3'd5, 4'd2, 3'd3, 32'h4, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if ({r_lat[3:0], r_op, r_den, r_cor, r_size, r_src, r_data} !==
          {4'd0, 3'd2, 1'b0, 1'b0, 4'd2, 3'd3, 64'd0}) begin
         n_fail++;
         $display("FAIL intent: got lat=%0d op=%0d den=%b cor=%b sz=%0d src=%0d data=%h",
                  r_lat, r_op, r_den, r_cor, r_size, r_src, r_data);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      bus.a_bits_opcode  = 3'd0;
      bus.a_bits_size    = 4'd3;
      bus.a_bits_source  = 3'd6;
      bus.a_bits_address = BASE + 32'h10;
      bus.a_bits_data    = 64'h0102_0304_0506_0708;
      bus.a_bits_corrupt = 1'b0;
      bus.d_ready        = 1'b1;
      bus.a_valid        = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.a_ready === 1'b1) acc++;
         @(posedge clock); #1;
      end
      n_cmp++;
      if (acc !== 5) begin
         n_fail++;
         $display("FAIL b2b_put: got %0d accepts want 5", acc);
      end
      bus.a_bits_opcode = 3'd4;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.a_ready === 1'b1) acc++;
         @(posedge clock); #1;
      end
      bus.a_valid = 1'b0;
      bus.d_ready = 1'b0;
      n_cmp++;
      if (acc !== 4) begin
         n_fail++;
         $display("FAIL b2b_get: got %0d accepts want 4", acc);
      end
      @(posedge clock); #1;
      send(3'd4, 4'd3, 3'd0, 32'h10, 64'd0, 1'b0);
      recv();
      n_cmp++;
      if (r_data !== 64'h0102_0304_0506_0708) begin
         n_fail++;
         $display("FAIL b2b_data: got %h want 0102030405060708", r_data);
      end
   endtask

   initial begin
      bus.a_valid        = 1'b0;
      bus.a_bits_opcode  = 3'd0;
      bus.a_bits_param   = 3'd0;
      bus.a_bits_size    = 4'd0;
      bus.a_bits_source  = 3'd0;
      bus.a_bits_address = 32'd0;
      bus.a_bits_data    = 64'd0;
      bus.a_bits_corrupt = 1'b0;
      bus.d_ready        = 1'b0;
      test_reset();
      test_put_get();
      test_byte_write();
      test_illegal();
      test_corrupt();
      test_unsupported();
      test_stall();
      test_reset_mid();
      test_intent();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tl_scratch_responder.md
# tl_scratch_responder

TileLink-UL manager-side responder that consumes A-channel requests (opcode/param/size/source/address/data/corrupt, 64-bit beat) and returns D-channel responses from a small single-beat scratchpad. It sits downstream of the 2-entry A-channel request queues at a crossbar edge and serves as the terminating device on a peripheral bus slot. It handles one outstanding request at a time and drives the D channel with a held, ready/valid-stable response.

## Interface
- BASE, 32'h0000_0000, byte base address of the scratchpad window (aligned to DEPTH*8)
- DEPTH, 16, number of 64-bit words (power of two, 2..256)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- io_a_valid / io_a_ready  in / out  1  A-channel handshake
- io_a_bits_opcode  in  3  Get=4, PutFullData=0, PutPartialData=1, Arithmetic=2, Logical=3, Intent=5
- io_a_bits_param  in  3  ignored
- io_a_bits_size  in  4  log2 bytes
- io_a_bits_source  in  3  requester ID
- io_a_bits_address  in  32  byte address
- io_a_bits_data  in  64  write data, byte lane = address[2:0]
- io_a_bits_corrupt  in  1  write data poisoned
- io_d_valid / io_d_ready  out / in  1  D-channel handshake
- io_d_bits_opcode  out  3  AccessAck=0, AccessAckData=1, HintAck=2
- io_d_bits_param / io_d_bits_sink  out  2 / 1  constant 0
- io_d_bits_size / io_d_bits_source  out  4 / 3  echoed from request
- io_d_bits_denied / io_d_bits_corrupt  out  1 / 1  error flags
- io_d_bits_data  out  64  read data, 0 for non-data responses

## Operation
- FSM: IDLE, READ, RESP. io_a_ready = (state==IDLE) & ~reset. Accept on a_valid & a_ready; latch opcode, size, source.
- Legal check: size<=3, address[size-1:0]==0, BASE <= address < BASE+DEPTH*8. Word index = (address-BASE)[3+:log2(DEPTH)].
- Byte mask = ((1<<(1<<size))-1) << address[2:0], 8 bits.
- Get, legal: synchronous memory read issued at accept; IDLE->READ->RESP; AccessAckData, data = full 64-bit word (all lanes), denied=0, corrupt=0.
- PutFull/PutPartial, legal, corrupt=0: masked write at accept edge; IDLE->RESP; AccessAck, denied=0. PutPartial treated as PutFull (no mask port).
- Put with corrupt=1: write suppressed; AccessAck, denied=1.
- Illegal Get/Put: no memory side effect; Get -> AccessAckData denied=1 corrupt=1 data=0; Put -> AccessAck denied=1.
- Arithmetic/Logical: unsupported; AccessAckData denied=1 corrupt=1 data=0, no side effect.
- Intent: HintAck, denied=0, no side effect. Opcodes 6,7 treated as Intent-illegal: AccessAck denied=1.
- RESP: d_valid=1, all d_bits held stable until d_ready; on handshake -> IDLE.

## Timing
- Reset: state=IDLE, io_d_valid=0, all io_d_bits=0, io_a_ready=0 while reset high, 1 the cycle after release. Memory contents not cleared.
- Get: accept at edge t -> d_valid high from t+2. Others: d_valid from t+1.
- a_ready low from accept edge until the edge where D handshake completes; earliest next accept one cycle after D handshake (no same-cycle turnaround). Peak throughput 1 per 2 cycles (Put), 1 per 3 (Get).
- d_ready held high in advance does not shorten latency. d_ready low stalls indefinitely with stable outputs.
- Read-after-write: Get accepted the cycle after a Put's D handshake returns the new data.
- Reset mid-transaction (READ or RESP): response dropped, d_valid low next cycle, write already performed stays.

## Structure
- Shared package tl_pkg: opcode constants (A and D), d-channel bundle typedef, mask helper function (size, addr[2:0] -> 8-bit mask).
- One sub-module: scratch_ram_sp, DEPTH x 64 single-port sync RAM with 8-bit byte-write enable, 1-cycle read latency.

## Test plan
- After reset, PutFull size=3 addr=BASE+0x8 data=0x1122334455667788, then Get size=3 same addr -> AccessAck denied=0 at t+1, then AccessAckData data=0x1122334455667788 at t+2.
- PutFull size=0 addr=BASE+0xB data=0x00000000_AB000000 onto word 0xFFFF..FF -> subsequent Get returns 0xFFFFFFFF_ABFFFFFF.
- Get addr=BASE+DEPTH*8 and Get size=2 addr=BASE+0x2 -> AccessAckData denied=1 corrupt=1 data=0; no memory change.
- Put with corrupt=1 to BASE -> AccessAck denied=1; Get BASE returns prior value. Get size=4 -> denied.
- Get with d_ready held low 10 cycles -> d_valid and all d_bits stable, a_ready low throughout; source=5, size=3 echoed.
- Assert reset while in RESP -> d_valid=0 next cycle, a_ready=1 one cycle after release; Intent request -> HintAck denied=0.
